spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Shares the single SPI register-interface master between NUM_REQ on-chip requesters, such as the host bridge, the debug port and the config loader.
- Accepts one read or write transaction per grant using round-robin arbitration.
- Packs each transaction into the master's 32-bit frame, pulses the master's tx_en, and times the fixed-length frame.
- Returns read data, or a write-complete pulse, to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- XFER_CYCLES, 36, clk cycles from spi_tx_en assertion to response capture; must be >= 34.
- IDLE_GAP, 2, clk cycles the block stays idle after DONE before the next launch, so SS stays high between frames.

Ports:
- clk  in  1  system clock; the SPI master runs on the negedge of the same clk.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- req  in  NUM_REQ  per-requester request; held with fields stable until req_ack.
- req_rw  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*14  register address; requester i occupies bits [14i+13:14i].
- req_wdata  in  NUM_REQ*16  write data; requester i occupies bits [16i+15:16i].
- req_ack  out  NUM_REQ  one-cycle grant/accept pulse, one-hot.
- resp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- resp_rdata  out  16  read data, valid with resp_valid; 0 for writes.
- busy  out  1  high in every state other than IDLE.
- spi_tx_en  out  1  frame start to the master.
- spi_tx_data  out  32  frame bits: [31:18] = addr, [17:16] = 0, [15:0] = wdata (0 for reads).
- spi_rw_mode  out  1  copy of the latched req_rw.
- spi_rx_data  in  16  master read result.
- spi_rx_en  in  1  master read strobe; sticky, used only for assertion checking.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; RR pointer = 0; cycle counter = 0.
- FSM states:
  - IDLE: if any req is high, grant the first requester at or after the pointer (wrapping modulo NUM_REQ). In the same cycle: pulse req_ack[g], latch addr/wdata/rw/owner, set pointer = g+1 (wrapping). Next state LAUNCH.
  - LAUNCH: spi_tx_en = 1 for exactly this one cycle, with spi_tx_data and spi_rw_mode driven from the latches. Load counter = XFER_CYCLES-1. Next state WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0, go to DONE.
  - DONE: pulse resp_valid[owner]. resp_rdata = spi_rx_data for a read, 0 for a write. Load the gap counter. Next state GAP.
  - GAP: count IDLE_GAP cycles, then go to IDLE.
- Holding: spi_tx_data and spi_rw_mode keep their values from LAUNCH through GAP.
- spi_tx_en must never be high for two consecutive cycles. The master restarts the frame if tx_en is high when its counter is 0.
- Latency:
  - req to req_ack: 1 cycle when idle.
  - req_ack to resp_valid: XFER_CYCLES+1 cycles.
  - Back-to-back throughput: one transaction per XFER_CYCLES+IDLE_GAP+2 cycles.
- Simultaneous requests: strict round-robin. A requester that was just served has lowest priority next time.
- A req deasserted before ack is simply not granted; no state change.
- A req still high after its ack is treated as a new request and rearbitrated in the next IDLE.
- Requests arriving during non-IDLE states wait; nothing is dropped or queued beyond the req level.
- resp_rdata holds its value until the next DONE.
- Reset mid-transfer returns everything to reset values immediately. The top level drives the master's rst from ~rst_n so both blocks abort together.
- Checker: in DONE for a read, spi_rx_en must be 1. Implement this as a bench assertion; it does not affect RTL behaviour.

Decomposition:
- Package spi_ctrl_pkg holds:
  - state enum {IDLE, LAUNCH, WAIT, DONE, GAP}
  - constants FRAME_W=32, ADDR_W=14, DATA_W=16, RW_WRITE=1, RW_READ=0
  - function pack_frame(addr, wdata, rw)
- Sub-module rr_arbiter (NUM_REQ, req, en, gnt one-hot, pointer update). It is reusable for the later DMA scheduler.

Test Plan:
- Single write: req[0] with addr 14'h0A5, wdata 16'hBEEF, rw=1 -> req_ack[0] next cycle; spi_tx_en high for one cycle with tx_data 32'h0294BEEF; resp_valid[0] 37 cycles after ack; resp_rdata = 0.
- Single read against an SPI slave model returning 16'h1234 for addr 14'h010 -> spi_tx_data = 32'h00400000, rw_mode = 0; resp_valid[1] with resp_rdata = 16'h1234; spi_rx_en observed high in DONE.
- All four requesters high continuously from reset -> grant order 0,1,2,3,0; SS deasserted for at least IDLE_GAP cycles between frames; no doubled tx_en.
- Requester 2 just served and requesters 2 and 3 both request -> grant goes to 3 first, then 2.
- rst_n asserted 10 cycles into WAIT -> all outputs 0 asynchronously. After release, a new read of addr 14'h3FFF completes correctly with no stale resp_valid.
- req[1] pulsed for one cycle while busy, then dropped -> no req_ack[1] and no SPI frame issued for it.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types, widths and helpers for the SPI transaction arbiter slice.
//
// Contents:
//   state_t    - transaction FSM states (IDLE, LAUNCH, WAIT, DONE, GAP)
//   FRAME_W    - width of one SPI master frame
//   ADDR_W     - register address width
//   DATA_W     - register data width
//   RW_WRITE / RW_READ - encoding of the rw flag
//   pack_frame - builds the 32-bit frame handed to the SPI master
package spi_ctrl_pkg;

  localparam int FRAME_W = 32;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 16;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE,
    GAP
  } state_t;

  // Frame layout: address in the top 14 bits, two reserved zero bits,
  // write data in the low half. Reads send zeros in the data field.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] wdata,
    input logic              rw
  );
    logic [DATA_W-1:0] data;
    data = (rw == RW_WRITE) ? wdata : {DATA_W{1'b0}};
    return {addr, 2'b00, data};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//
// Ports:
//   i_clk     - clock
//   i_rst_n   - asynchronous active-low reset (pointer returns to 0)
//   i_req     - request vector
//   i_en      - arbitration enable; no grant and no pointer move when low
//   o_gnt     - one-hot grant (combinational)
//   o_gntIdx  - index of the granted requester
//
// The first requester at or after the pointer wins, and after a grant the
// pointer moves to the slot just past the winner, so the winner has the
// lowest priority next time.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_gntIdx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Walk the requesters starting at the pointer, wrapping modulo NUM_REQ
  // with a subtract so non-power-of-two counts work too.
  always_comb begin
    o_gnt    = '0;
    o_gntIdx = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!w_found && i_en && i_req[w_idx]) begin
        w_found     = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gntIdx    = w_idx;
      end
    end
  end

  // Pointer moves to the slot after the winner on every grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (o_gntIdx == IDX_W'(NUM_REQ-1)) ? '0 : o_gntIdx + 1'b1;
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI register-interface master between NUM_REQ requesters.
// One read or write is accepted per grant (round-robin), packed into a
// 32-bit frame, launched with a single-cycle spi_tx_en, timed for
// XFER_CYCLES and answered with resp_valid/resp_rdata. After each
// transaction the block idles IDLE_GAP cycles so SS stays high between
// frames. The SPI master's own reset is driven from ~rst_n at the
// integration level so both blocks abort together.
//
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   req/req_rw         - per-requester request and direction (1 = write)
//   req_addr/req_wdata - packed per-requester address and write data
//   req_ack            - one-cycle one-hot accept pulse
//   resp_valid         - one-cycle completion pulse to the owner
//   resp_rdata         - read data (0 for writes), held until next DONE
//   busy               - high whenever the FSM is not IDLE
//   spi_tx_en          - frame start to the master
//   spi_tx_data        - frame {addr, 2'b00, wdata}
//   spi_rw_mode        - latched direction
//   spi_rx_data        - master read result
//   spi_rx_en          - master read strobe (observed only by checkers)
//
// IDLE_GAP must be at least 1 and XFER_CYCLES at least 34.
module spi_txn_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int XFER_CYCLES = 36,
  parameter int IDLE_GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [NUM_REQ*14-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [15:0]           resp_rdata,
  output logic                  busy,
  output logic                  spi_tx_en,
  output logic [31:0]           spi_tx_data,
  output logic                  spi_rw_mode,
  input  logic [15:0]           spi_rx_data,
  input  logic                  spi_rx_en
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(XFER_CYCLES + IDLE_GAP + 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [CNT_W-1:0]     r_cnt;
  logic [FRAME_W-1:0]   r_txData;
  logic                 r_rw;
  logic [IDX_W-1:0]     r_owner;
  logic [DATA_W-1:0]    r_rdata;

  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]     w_gntIdx;
  logic                 w_arbEn;
  logic [ADDR_W-1:0]    w_gntAddr;
  logic [DATA_W-1:0]    w_gntWdata;
  logic                 w_gntRw;
  logic [DATA_W-1:0]    w_doneRdata;
  logic                 w_unused;

  // The sticky read strobe is only watched by checkers outside this block.
  assign w_unused = spi_rx_en;

  assign w_arbEn = (r_state == IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .i_en     (w_arbEn),
    .o_gnt    (w_gnt),
    .o_gntIdx (w_gntIdx)
  );

  // Select the winner's fields from the packed request buses.
  always_comb begin
    w_gntAddr  = '0;
    w_gntWdata = '0;
    w_gntRw    = RW_READ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gntAddr  = req_addr[i*ADDR_W +: ADDR_W];
        w_gntWdata = req_wdata[i*DATA_W +: DATA_W];
        w_gntRw    = req_rw[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and the state-decoded pulse outputs. WAIT leaves when the
  // counter is about to reach 0, so LAUNCH to DONE spans XFER_CYCLES clocks.
  always_comb begin
    w_nextState = r_state;
    req_ack     = '0;
    resp_valid  = '0;
    spi_tx_en   = 1'b0;
    busy        = 1'b1;
    w_doneRdata = r_rdata;
    case (r_state)
      IDLE: begin
        busy    = 1'b0;
        req_ack = w_gnt;
        if (|w_gnt) w_nextState = LAUNCH;
      end
      LAUNCH: begin
        spi_tx_en   = 1'b1;
        w_nextState = WAIT;
      end
      WAIT: begin
        if (r_cnt == CNT_W'(1)) w_nextState = DONE;
      end
      DONE: begin
        resp_valid[r_owner] = 1'b1;
        w_doneRdata = (r_rw == RW_WRITE) ? '0 : spi_rx_data;
        w_nextState = GAP;
      end
      GAP: begin
        if (r_cnt == '0) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Transaction latches and the shared frame/gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_txData <= '0;
      r_rw     <= 1'b0;
      r_owner  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_txData <= pack_frame(w_gntAddr, w_gntWdata, w_gntRw);
            r_rw     <= w_gntRw;
            r_owner  <= w_gntIdx;
          end
        end
        LAUNCH: r_cnt <= CNT_W'(XFER_CYCLES - 1);
        WAIT:   r_cnt <= r_cnt - 1'b1;
        DONE: begin
          r_rdata <= w_doneRdata;
          r_cnt   <= CNT_W'(IDLE_GAP - 1);
        end
        GAP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata  = w_doneRdata;
  assign spi_tx_data = r_txData;
  assign spi_rw_mode = r_rw;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized and directed bench for spi_txn_arbiter. A transaction-level
// model predicts grants (round-robin over the request levels), the launch,
// response timing and read data; a small SPI slave answers reads.
module tb_spi_txn_arbiter;

  localparam int N    = 4;
  localparam int XFER = 36;
  localparam int GAPC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]    req, req_rw;
  logic [N*14-1:0] req_addr;
  logic [N*16-1:0] req_wdata;
  logic [N-1:0]    req_ack, resp_valid;
  logic [15:0]     resp_rdata;
  logic            busy, spi_tx_en, spi_rw_mode;
  logic [31:0]     spi_tx_data;
  logic [15:0]     spi_rx_data;
  logic            spi_rx_en;

  spi_txn_arbiter #(.NUM_REQ(N), .XFER_CYCLES(XFER), .IDLE_GAP(GAPC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ack     (req_ack),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .busy        (busy),
    .spi_tx_en   (spi_tx_en),
    .spi_tx_data (spi_tx_data),
    .spi_rw_mode (spi_rw_mode),
    .spi_rx_data (spi_rx_data),
    .spi_rx_en   (spi_rx_en)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // requester side
  bit          reqOn[N];
  bit          reqRwA[N];
  logic [13:0] reqAddrA[N];
  logic [15:0] reqWdA[N];
  bit          holdAfter[N];
  bit          keepAll;

  // transaction-level model
  int          freeAt, launchAt, respAt, ptr, curOwner;
  bit          curRw;
  logic [13:0] curAddr;
  logic [15:0] curWd;
  logic [15:0] lastRdata;

  // observations used by directed checks
  int   grantLog[$];
  int   ackCycObs, respCycObs, respCnt, txCnt, prevTxCyc, minTxGap;
  logic [31:0] lastTxObs;
  logic rxEnAtResp;

  // SPI slave model
  int          slaveCnt;
  logic [13:0] slaveAddr;
  bit          slaveRw;
  logic [15:0] slaveData;
  logic        slaveEn;

  function automatic logic [15:0] slaveMem(input logic [13:0] a);
    if (a == 14'h010) return 16'h1234;
    return {2'b00, a} ^ 16'h5A3C;
  endfunction

  function automatic logic [31:0] frameOf(input logic [13:0] a, input logic [15:0] d, input bit rw);
    return (32'(a) << 18) | (rw ? 32'(d) : 32'd0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic randomFields(input int i);
    reqRwA[i]   = 1'($urandom);
    reqAddrA[i] = ($urandom % 8 == 0) ? 14'h010 : 14'($urandom);
    reqWdA[i]   = 16'($urandom);
  endtask

  task automatic setReq(input int i, input bit rw, input logic [13:0] a, input logic [15:0] d, input bit hold);
    reqOn[i] = 1'b1; reqRwA[i] = rw; reqAddrA[i] = a; reqWdA[i] = d; holdAfter[i] = hold;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      req[i]               = reqOn[i];
      req_rw[i]            = reqRwA[i];
      req_addr[i*14 +: 14] = reqAddrA[i];
      req_wdata[i*16 +: 16] = reqWdA[i];
    end
    spi_rx_data = slaveData;
    spi_rx_en   = slaveEn;
  endtask

  function automatic int oneHotIdx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Predict this cycle from the current request levels, then compare.
  task automatic modelAndCheck();
    logic [N-1:0] expAck, expResp;
    bit idle;
    int g;
    expAck  = '0;
    expResp = '0;
    idle    = (cyc >= freeAt);
    g       = -1;
    checkOutput("busy", 32'(busy), 32'(!idle));
    if (idle) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (ptr + k) % N;
        if (g < 0 && reqOn[j]) g = j;
      end
    end
    if (g >= 0) begin
      expAck[g] = 1'b1;
      ptr       = (g + 1) % N;
      curOwner  = g; curRw = reqRwA[g]; curAddr = reqAddrA[g]; curWd = reqWdA[g];
      launchAt  = cyc + 1;
      respAt    = cyc + XFER + 1;
      freeAt    = cyc + XFER + GAPC + 2;
      if (keepAll || holdAfter[g]) begin
        holdAfter[g] = 1'b0;
        randomFields(g);
      end else begin
        reqOn[g] = 1'b0;
      end
    end
    checkOutput("req_ack", 32'(req_ack), 32'(expAck));
    checkOutput("spi_tx_en", 32'(spi_tx_en), 32'(cyc == launchAt));
    if (launchAt >= 0 && cyc >= launchAt && cyc < freeAt) begin
      checkOutput("spi_tx_data", spi_tx_data, frameOf(curAddr, curWd, curRw));
      checkOutput("spi_rw_mode", 32'(spi_rw_mode), 32'(curRw));
    end
    if (cyc == respAt) begin
      expResp[curOwner] = 1'b1;
      lastRdata = curRw ? 16'h0000 : slaveMem(curAddr);
      if (!curRw) checkOutput("rxEnInDone", 32'(spi_rx_en), 32'd1);
    end
    checkOutput("resp_valid", 32'(resp_valid), 32'(expResp));
    checkOutput("resp_rdata", 32'(resp_rdata), 32'(lastRdata));
    // observations
    if (req_ack != '0) begin grantLog.push_back(oneHotIdx(req_ack)); ackCycObs = cyc; end
    if (resp_valid != '0) begin respCycObs = cyc; respCnt++; rxEnAtResp = spi_rx_en; end
    if (spi_tx_en) begin
      txCnt++; lastTxObs = spi_tx_data;
      if (prevTxCyc >= 0 && cyc - prevTxCyc < minTxGap) minTxGap = cyc - prevTxCyc;
      prevTxCyc = cyc;
      slaveAddr = spi_tx_data[31:18]; slaveRw = spi_rw_mode; slaveCnt = 20; slaveEn = 1'b0;
    end else if (slaveCnt > 0) begin
      slaveCnt--;
      if (slaveCnt == 0) begin
        slaveData = slaveRw ? 16'hDEAD : slaveMem(slaveAddr);
        slaveEn   = !slaveRw;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    applyStimulus();
    @(negedge clk);
    modelAndCheck();
  endtask

  function automatic bit anyReq();
    for (int i = 0; i < N; i++) if (reqOn[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic runUntilIdle(input int maxCyc);
    int n;
    n = 0;
    do begin step(); n++; end while ((cyc < freeAt || anyReq()) && n < maxCyc);
    if (n >= maxCyc) checkOutput("idleTimeout", 32'd0, 32'd1);
  endtask

  task automatic clearModel();
    for (int i = 0; i < N; i++) begin reqOn[i] = 0; holdAfter[i] = 0; end
    keepAll = 0; freeAt = 0; launchAt = -1; respAt = -1; ptr = 0; lastRdata = '0;
    slaveCnt = 0; slaveData = '0; slaveEn = 1'b0; prevTxCyc = -1; minTxGap = 1000000;
    grantLog.delete(); respCnt = 0; txCnt = 0;
  endtask

  // Asynchronous reset assertion away from the clock edge, then release.
  task automatic resetDut(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, "_req_ack"}, 32'(req_ack), 32'd0);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_resp_rdata"}, 32'(resp_rdata), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_tx_en"}, 32'(spi_tx_en), 32'd0);
    checkOutput({tag, "_tx_data"}, spi_tx_data, 32'd0);
    checkOutput({tag, "_rw_mode"}, 32'(spi_rw_mode), 32'd0);
    clearModel();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid != '0 && !spi_rw_mode)
      assert (spi_rx_en) else $error("[TB] FAIL rxEnAssert: spi_rx_en low in DONE for a read");
  end

  int expOrder[5] = '{0, 1, 2, 3, 0};

  initial begin
    int n;
    rst_n = 1'b0;
    clearModel();
    for (int i = 0; i < N; i++) begin reqRwA[i] = 0; reqAddrA[i] = '0; reqWdA[i] = '0; end
    applyStimulus();
    resetDut("rst0");

    // single write from requester 0
    $display("[TB] single write");
    setReq(0, 1'b1, 14'h0A5, 16'hBEEF, 1'b0);
    runUntilIdle(200);
    checkOutput("wrFrame", lastTxObs, 32'h0294BEEF);
    checkOutput("wrLatency", 32'(respCycObs - ackCycObs), 32'd37);
    checkOutput("wrRdata", 32'(resp_rdata), 32'd0);

    // single read from requester 1
    $display("[TB] single read");
    setReq(1, 1'b0, 14'h010, 16'hFFFF, 1'b0);
    runUntilIdle(200);
    checkOutput("rdFrame", lastTxObs, 32'h00400000);
    checkOutput("rdData", 32'(resp_rdata), 32'h1234);
    checkOutput("rdRxEn", 32'(rxEnAtResp), 32'd1);

    // all four held high from reset
    $display("[TB] continuous round robin");
    resetDut("rst1");
    keepAll = 1'b1;
    for (int i = 0; i < N; i++) begin reqOn[i] = 1'b1; randomFields(i); end
    n = 0;
    while (grantLog.size() < 5 && n < 400) begin step(); n++; end
    if (grantLog.size() < 5) checkOutput("rrTimeout", 32'(grantLog.size()), 32'd5);
    else for (int k = 0; k < 5; k++) checkOutput($sformatf("rrOrder%0d", k), 32'(grantLog[k]), 32'(expOrder[k]));
    keepAll = 1'b0;
    runUntilIdle(600);
    checkOutput("txSpacing", 32'(minTxGap >= XFER + GAPC + 2), 32'd1);

    // requester 2 just served, then 2 and 3 compete
    $display("[TB] fairness after service");
    resetDut("rst2");
    setReq(2, 1'b1, 14'h123, 16'h0F0F, 1'b0);
    runUntilIdle(200);
    grantLog.delete();
    setReq(2, 1'b0, 14'h200, 16'h0, 1'b0);
    setReq(3, 1'b1, 14'h300, 16'hA5A5, 1'b0);
    runUntilIdle(300);
    checkOutput("fairCount", 32'(grantLog.size()), 32'd2);
    if (grantLog.size() == 2) begin
      checkOutput("fairFirst", 32'(grantLog[0]), 32'd3);
      checkOutput("fairSecond", 32'(grantLog[1]), 32'd2);
    end

    // reset 10 cycles into WAIT, then a clean read of 0x3FFF
    $display("[TB] reset mid transfer");
    setReq(0, 1'b0, 14'h3FFF, 16'h0, 1'b0);
    n = 0;
    do begin step(); n++; end while (!(launchAt >= 0 && cyc == launchAt + 10) && n < 100);
    if (n >= 100) checkOutput("midTimeout", 32'd0, 32'd1);
    resetDut("rstMid");
    setReq(3, 1'b0, 14'h3FFF, 16'h0, 1'b0);
    runUntilIdle(200);
    checkOutput("postRstResp", 32'(respCnt), 32'd1);
    checkOutput("postRstData", 32'(resp_rdata), 32'(slaveMem(14'h3FFF)));

    // short pulse on req[1] while busy is never granted
    $display("[TB] dropped request");
    grantLog.delete(); txCnt = 0;
    setReq(0, 1'b1, 14'h055, 16'h1111, 1'b0);
    repeat (5) step();
    setReq(1, 1'b1, 14'h066, 16'h2222, 1'b0);
    step();
    reqOn[1] = 1'b0;
    runUntilIdle(200);
    checkOutput("dropGrants", 32'(grantLog.size()), 32'd1);
    checkOutput("dropFrames", 32'(txCnt), 32'd1);

    // randomized traffic
    $display("[TB] random traffic");
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!reqOn[i] && $urandom % 8 == 0) begin
          reqOn[i] = 1'b1; randomFields(i); holdAfter[i] = ($urandom % 4 == 0);
        end else if (reqOn[i] && $urandom % 64 == 0) begin
          reqOn[i] = 1'b0;
        end
      end
      step();
    end
    runUntilIdle(800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
